frame_streamer: RTL and testbench
=================================

FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 Parameter ROW_SZ, default 320, pixels per row.
REQ-002 Parameter COL_SZ, default 240, rows per frame.
REQ-003 Parameter ADDR_W, default 17, frame-buffer address width; ROW_SZ*COL_SZ SHALL be at most 2^ADDR_W.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to stream a frame.
REQ-007 continuous  in  1  at frame end, restart at (0,0) instead of stopping.
REQ-008 hold  in  1  suppresses new reads while high.
REQ-009 pix_gap  in  4  minimum idle cycles between consecutive reads.
REQ-010 rd_en  out  1  frame-buffer read strobe.
REQ-011 rd_addr  out  ADDR_W  frame-buffer read address, y*ROW_SZ+x.
REQ-012 rd_data  in  8  frame-buffer data, valid one cycle after rd_en.
REQ-013 out_val  out  8  streamed pixel.
REQ-014 out_x  out  10  column of out_val.
REQ-015 out_y  out  10  row of out_val.
REQ-016 is_out_val  out  1  pixel strobe, one cycle per pixel.
REQ-017 busy  out  1  high from the first read issue until the last pixel is emitted.
REQ-018 frame_done  out  1  one-cycle pulse on the last pixel of each frame.

Function
REQ-019 FSM states SHALL be IDLE, RUN and GAP; reset state SHALL be IDLE.
REQ-020 IDLE->RUN SHALL occur on start=1; start SHALL be ignored outside IDLE.
REQ-021 In RUN with hold=0, rd_en=1 SHALL be issued with the current raster address, then the raster counter SHALL advance; hold=1 SHALL keep rd_en=0 and freeze the counter.
REQ-022 After each issue, the FSM SHALL go to GAP for exactly pix_gap cycles, counted only while hold=0; pix_gap=0 SHALL skip GAP, giving one read per cycle.
REQ-023 The raster counter SHALL step x 0..ROW_SZ-1, then wrap x to 0 and increment y; after (ROW_SZ-1, COL_SZ-1) it SHALL wrap to (0,0) with address 0.
REQ-024 After the last-pixel issue, the FSM SHALL return to IDLE if continuous=0, or continue in RUN/GAP if continuous=1 (sampled on that issue cycle).
REQ-025 Latency: with start sampled at edge k, rd_en SHALL be 1 with rd_addr=0 in cycle k+1, and is_out_val SHALL be 1 with out_x=0, out_y=0 in cycle k+2.
REQ-026 is_out_val, out_x and out_y SHALL be registered copies of rd_en and the issued x/y, delayed one cycle; out_val SHALL equal rd_data in that cycle.
REQ-027 A read already issued when hold rises SHALL still be emitted; hold SHALL never drop or duplicate a pixel.
REQ-028 frame_done SHALL coincide with the is_out_val of pixel (ROW_SZ-1, COL_SZ-1).
REQ-029 busy SHALL fall in the cycle after the final is_out_val of a non-continuous frame.
REQ-030 The output stream SHALL be exactly raster order with no gaps in x/y sequence, directly consumable by the team's streaming convolution/census blocks.

Reset
REQ-031 reset_n=0 SHALL asynchronously clear the FSM to IDLE, counters to 0, and every output (rd_en, rd_addr, out_x, out_y, is_out_val, busy, frame_done) to 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame; no is_out_val SHALL follow deassertion until a new start.

Structure
REQ-033 ROW_SZ/COL_SZ defaults, coordinate width (10) and the FSM state encoding SHALL live in the shared image-pipeline package.
REQ-034 The x/y/address counter with wrap SHALL be a sub-module named raster_counter (inputs: step, clear; outputs: x, y, addr, last).

Verification (bench uses ROW_SZ=4, COL_SZ=3, memory preloaded with mem[a]=a+16)
REQ-035 Start pulse, pix_gap=0, hold=0, continuous=0 -> 12 consecutive is_out_val cycles starting 2 cycles after start, out_val 16..27, (x,y) (0,0)..(3,2), frame_done with (3,2), busy low afterward.
REQ-036 pix_gap=2 -> is_out_val exactly every 3 cycles, 12 pixels, identical values.
REQ-037 hold high for 5 cycles, starting the cycle after pixel (1,0) is issued -> pixel (1,0) still emitted, no strobes for 5 cycles, then (2,0) with value 18; sequence has no duplicates.
REQ-038 continuous=1 for two frames -> (3,2) value 27 immediately followed by (0,0) value 16 at full rate; two frame_done pulses.
REQ-039 reset_n low at pixel (2,1), released, second start -> all outputs 0 during reset, no strobe before new start, and the new frame begins at (0,0).
REQ-040 start pulsed again while busy -> ignored; exactly 12 pixels and one frame_done.

Source files
------------

// File: rtl/frame_streamer_pkg.sv
// Shared image-pipeline definitions: frame geometry defaults, coordinate width, FSM encoding.
package frame_streamer_pkg;

    localparam int unsigned ROW_SZ_DEF = 320;
    localparam int unsigned COL_SZ_DEF = 240;
    localparam int unsigned ADDR_W_DEF = 17;
    localparam int unsigned COORD_W    = 10;
    localparam int unsigned GAP_W      = 4;
    localparam int unsigned PIX_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Raster position of a pixel travelling down the pipeline
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pix_pos_t;

endpackage

// File: rtl/frame_streamer_raster_counter.sv
// Raster x/y/address counter; wraps x at row end and the whole frame back to (0,0).
module raster_counter
    import frame_streamer_pkg::*;
#(
    parameter int unsigned ROW_SZ = ROW_SZ_DEF,
    parameter int unsigned COL_SZ = COL_SZ_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               step,
    input  logic               clear,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               last
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(ROW_SZ - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(COL_SZ - 1);

    logic x_end;

    assign x_end = (x == X_MAX);
    assign last  = x_end && (y == Y_MAX);

    // Advance one pixel per step; the address tracks y*ROW_SZ+x by simple increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (step) begin
            if (last) begin
                x    <= '0;
                y    <= '0;
                addr <= '0;
            end else if (x_end) begin
                x    <= '0;
                y    <= y + COORD_W'(1);
                addr <= addr + ADDR_W'(1);
            end else begin
                x    <= x + COORD_W'(1);
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_streamer.sv
// Streams a frame buffer out in raster order with programmable read spacing and hold.
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int unsigned ROW_SZ = ROW_SZ_DEF,
    parameter int unsigned COL_SZ = COL_SZ_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               continuous,
    input  logic               hold,
    input  logic [GAP_W-1:0]   pix_gap,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [PIX_W-1:0]   rd_data,
    output logic [PIX_W-1:0]   out_val,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               is_out_val,
    output logic               busy,
    output logic               frame_done
);

    state_t             state;
    state_t             state_nxt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               issue;
    logic               clear;
    logic               gap_tick;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               cur_last;
    pix_pos_t           pos_q;

    raster_counter #(
        .ROW_SZ (ROW_SZ),
        .COL_SZ (COL_SZ),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (issue),
        .clear   (clear),
        .x       (cur_x),
        .y       (cur_y),
        .addr    (rd_addr),
        .last    (cur_last)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a read leaves RUN for GAP unless spacing is zero or the frame ends
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!hold) begin
                    if (cur_last && !continuous) begin
                        state_nxt = IDLE;
                    end else if (pix_gap != '0) begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (!hold && (gap_cnt == GAP_W'(1))) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state controls: read issue, counter clear, gap countdown
    always_comb begin
        issue    = 1'b0;
        clear    = 1'b0;
        gap_tick = 1'b0;
        case (state)
            IDLE:    clear    = start;
            RUN:     issue    = !hold;
            GAP:     gap_tick = !hold;
            default: ;
        endcase
    end

    assign rd_en   = issue;
    assign out_val = rd_data;
    assign out_x   = pos_q.x;
    assign out_y   = pos_q.y;

    // Idle-cycle counter between reads; frozen while hold is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt <= '0;
        end else if (issue) begin
            gap_cnt <= pix_gap;
        end else if (gap_tick) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    // Output strobe and coordinates trail the read by one cycle to line up with rd_data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_out_val <= 1'b0;
            frame_done <= 1'b0;
            pos_q      <= '0;
        end else begin
            is_out_val <= issue;
            frame_done <= issue && cur_last;
            if (issue) begin
                pos_q.x <= cur_x;
                pos_q.y <= cur_y;
            end
        end
    end

    // Busy from accepted start until the final pixel of a stopping frame has been emitted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
        end else if ((state == IDLE) && start) begin
            busy <= 1'b1;
        end else if ((state == IDLE) && frame_done) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer on a 4x3 frame with mem[a] = a + 16.
module tb_frame_streamer;

    localparam int unsigned ROW  = 4;
    localparam int unsigned COL  = 3;
    localparam int unsigned AW   = 4;
    localparam int unsigned NPIX = ROW * COL;
    localparam int unsigned OBSN = 512;

    typedef struct packed {
        int unsigned cyc;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [7:0]  val;
        logic        done;
    } pix_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          hold = 1'b0;
    logic [3:0]    pix_gap = 4'd0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data = 8'd0;
    logic [7:0]    out_val;
    logic [9:0]    out_x;
    logic [9:0]    out_y;
    logic          is_out_val;
    logic          busy;
    logic          frame_done;

    logic [7:0]    mem [16];
    int unsigned   cyc = 0;
    pix_t          obs [OBSN];
    int unsigned   obs_n = 0;
    pix_t          exp_q [$];
    int            errors = 0;
    int            checks = 0;

    frame_streamer #(
        .ROW_SZ (ROW),
        .COL_SZ (COL),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .continuous (continuous),
        .hold       (hold),
        .pix_gap    (pix_gap),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_val    (out_val),
        .out_x      (out_x),
        .out_y      (out_y),
        .is_out_val (is_out_val),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous frame-buffer model
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // Record every output strobe with the cycle it appeared in
    always @(negedge clk) begin
        if (is_out_val && (obs_n < OBSN)) begin
            obs[obs_n] <= '{cyc: cyc, x: out_x, y: out_y, val: out_val, done: frame_done};
            obs_n      <= obs_n + 1;
        end
    end

    function automatic pix_t model_pix(int unsigned c, int unsigned i);
        pix_t        p;
        int unsigned j;
        j      = i % NPIX;
        p.cyc  = c;
        p.x    = 10'(j % ROW);
        p.y    = 10'(j / ROW);
        p.val  = 8'(16 + j);
        p.done = (j == NPIX - 1);
        return p;
    endfunction

    task automatic tick_to(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(output int unsigned k);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = cyc;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rd_en, rd_addr, out_x, out_y, is_out_val, busy, frame_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd_en=%b addr=%0d x=%0d y=%0d v=%b busy=%b done=%b want all 0",
                     rd_en, rd_addr, out_x, out_y, is_out_val, busy, frame_done);
        end
        reset_n = 1'b1;
        tick_to(cyc + 2);
    endtask

    task automatic test_single_frame;
        int unsigned k;
        int unsigned base;
        pix_t        e;
        pix_t        g;
        pix_gap = 4'd0;
        base    = obs_n;
        pulse_start(k);
        for (int i = 0; i < int'(NPIX); i++) exp_q.push_back(model_pix(k + 1 + i, i));
        checks++;
        if ({rd_en, rd_addr, busy} !== {1'b1, AW'(0), 1'b1}) begin
            errors++;
            $display("FAIL single first_read: got rd_en=%b addr=%0d busy=%b want 1 0 1", rd_en, rd_addr, busy);
        end
        tick_to(k + 12);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single busy_last: got %b want 1", busy);
        end
        tick_to(k + 13);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single busy_after: got %b want 0", busy);
        end
        tick_to(k + 18);
        checks++;
        if (obs_n - base !== NPIX) begin
            errors++;
            $display("FAIL single count: got %0d want %0d", obs_n - base, NPIX);
        end
        for (int i = 0; i < int'(NPIX); i++) begin
            e = exp_q.pop_front();
            g = obs[base + i];
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL single pix%0d: got cyc=%0d x=%0d y=%0d v=%0d d=%b want cyc=%0d x=%0d y=%0d v=%0d d=%b",
                         i, g.cyc, g.x, g.y, g.val, g.done, e.cyc, e.x, e.y, e.val, e.done);
            end
        end
    endtask

    task automatic test_gap;
        int unsigned k;
        int unsigned base;
        pix_t        e;
        pix_t        g;
        pix_gap = 4'd2;
        base    = obs_n;
        pulse_start(k);
        for (int i = 0; i < int'(NPIX); i++) exp_q.push_back(model_pix(k + 1 + 3 * i, i));
        tick_to(k + 40);
        pix_gap = 4'd0;
        checks++;
        if (obs_n - base !== NPIX) begin
            errors++;
            $display("FAIL gap count: got %0d want %0d", obs_n - base, NPIX);
        end
        for (int i = 0; i < int'(NPIX); i++) begin
            e = exp_q.pop_front();
            g = obs[base + i];
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL gap pix%0d: got cyc=%0d x=%0d y=%0d v=%0d d=%b want cyc=%0d x=%0d y=%0d v=%0d d=%b",
                         i, g.cyc, g.x, g.y, g.val, g.done, e.cyc, e.x, e.y, e.val, e.done);
            end
        end
    endtask

    task automatic test_hold;
        int unsigned k;
        int unsigned base;
        pix_t        e;
        pix_t        g;
        pix_gap = 4'd0;
        base    = obs_n;
        pulse_start(k);
        for (int i = 0; i < int'(NPIX); i++)
            exp_q.push_back(model_pix((i < 2) ? (k + 1 + i) : (k + 6 + i), i));
        tick_to(k + 2);
        hold = 1'b1;
        tick_to(k + 7);
        hold = 1'b0;
        tick_to(k + 24);
        checks++;
        if (obs_n - base !== NPIX) begin
            errors++;
            $display("FAIL hold count: got %0d want %0d", obs_n - base, NPIX);
        end
        for (int i = 0; i < int'(NPIX); i++) begin
            e = exp_q.pop_front();
            g = obs[base + i];
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL hold pix%0d: got cyc=%0d x=%0d y=%0d v=%0d d=%b want cyc=%0d x=%0d y=%0d v=%0d d=%b",
                         i, g.cyc, g.x, g.y, g.val, g.done, e.cyc, e.x, e.y, e.val, e.done);
            end
        end
    endtask

    task automatic test_continuous;
        int unsigned k;
        int unsigned base;
        pix_t        e;
        pix_t        g;
        pix_gap    = 4'd0;
        continuous = 1'b1;
        base       = obs_n;
        pulse_start(k);
        for (int i = 0; i < int'(2 * NPIX); i++) exp_q.push_back(model_pix(k + 1 + i, i));
        tick_to(k + 15);
        continuous = 1'b0;
        tick_to(k + 30);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cont busy_after: got %b want 0", busy);
        end
        checks++;
        if (obs_n - base !== 2 * NPIX) begin
            errors++;
            $display("FAIL cont count: got %0d want %0d", obs_n - base, 2 * NPIX);
        end
        for (int i = 0; i < int'(2 * NPIX); i++) begin
            e = exp_q.pop_front();
            g = obs[base + i];
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cont pix%0d: got cyc=%0d x=%0d y=%0d v=%0d d=%b want cyc=%0d x=%0d y=%0d v=%0d d=%b",
                         i, g.cyc, g.x, g.y, g.val, g.done, e.cyc, e.x, e.y, e.val, e.done);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int unsigned k;
        int unsigned base;
        pix_t        e;
        pix_t        g;
        pix_gap = 4'd0;
        base    = obs_n;
        pulse_start(k);
        for (int i = 0; i < 6; i++) exp_q.push_back(model_pix(k + 1 + i, i));
        tick_to(k + 7);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rd_en, rd_addr, out_x, out_y, is_out_val, busy, frame_done} !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs: got rd_en=%b addr=%0d x=%0d y=%0d v=%b busy=%b done=%b want all 0",
                     rd_en, rd_addr, out_x, out_y, is_out_val, busy, frame_done);
        end
        tick_to(k + 9);
        reset_n = 1'b1;
        tick_to(k + 19);
        checks++;
        if (obs_n - base !== 6) begin
            errors++;
            $display("FAIL rst_mid count: got %0d want 6", obs_n - base);
        end
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            g = obs[base + i];
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL rst_mid pix%0d: got cyc=%0d x=%0d y=%0d v=%0d d=%b want cyc=%0d x=%0d y=%0d v=%0d d=%b",
                         i, g.cyc, g.x, g.y, g.val, g.done, e.cyc, e.x, e.y, e.val, e.done);
            end
        end
        base = obs_n;
        pulse_start(k);
        for (int i = 0; i < int'(NPIX); i++) exp_q.push_back(model_pix(k + 1 + i, i));
        tick_to(k + 18);
        checks++;
        if (obs_n - base !== NPIX) begin
            errors++;
            $display("FAIL rst_restart count: got %0d want %0d", obs_n - base, NPIX);
        end
        for (int i = 0; i < int'(NPIX); i++) begin
            e = exp_q.pop_front();
            g = obs[base + i];
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL rst_restart pix%0d: got cyc=%0d x=%0d y=%0d v=%0d d=%b want cyc=%0d x=%0d y=%0d v=%0d d=%b",
                         i, g.cyc, g.x, g.y, g.val, g.done, e.cyc, e.x, e.y, e.val, e.done);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int unsigned k;
        int unsigned base;
        pix_t        e;
        pix_t        g;
        pix_gap = 4'd0;
        base    = obs_n;
        pulse_start(k);
        for (int i = 0; i < int'(NPIX); i++) exp_q.push_back(model_pix(k + 1 + i, i));
        tick_to(k + 4);
        start = 1'b1;
        tick_to(k + 5);
        start = 1'b0;
        tick_to(k + 10);
        start = 1'b1;
        tick_to(k + 11);
        start = 1'b0;
        tick_to(k + 24);
        checks++;
        if (obs_n - base !== NPIX) begin
            errors++;
            $display("FAIL busy_start count: got %0d want %0d", obs_n - base, NPIX);
        end
        for (int i = 0; i < int'(NPIX); i++) begin
            e = exp_q.pop_front();
            g = obs[base + i];
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL busy_start pix%0d: got cyc=%0d x=%0d y=%0d v=%0d d=%b want cyc=%0d x=%0d y=%0d v=%0d d=%b",
                         i, g.cyc, g.x, g.y, g.val, g.done, e.cyc, e.x, e.y, e.val, e.done);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start busy_after: got %b want 0", busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 8'(a + 16);
        test_reset();
        test_single_frame();
        test_gap();
        test_hold();
        test_continuous();
        test_reset_midframe();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
